// File: rtl/cnn_pkg.sv
// cnn_pkg: shared definitions for the convolution-engine dispatcher.
//   - disp_state_e : dispatcher sequencing states (FILL, START, WAIT, DRAIN)
//   - img_n/out_n  : element counts of the input image and the 3x3-valid feature map
//   - cnt_w        : bit width of a counter that indexes 0..n-1 (at least 1 bit)
package cnn_pkg;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } disp_state_e;

    function automatic int img_n(input int w, input int h);
        return w * h;
    endfunction

    // A 3x3 kernel without padding trims one pixel off every border.
    function automatic int out_n(input int w, input int h);
        return (w - 2) * (h - 2);
    endfunction

    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cnn_dispatcher_fmap_serializer.sv
// fmap_serializer: snapshots the engine's flat feature-map bus and replays it
// as a valid/ready stream, element 0 first.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   load              capture fmap and start presenting element 0 next cycle
//   fmap              flat feature map, element i at [i*OUT_W +: OUT_W]
//   m_valid/m_ready   result handshake (m_* registered, held while stalled)
//   m_data, m_last    current element and final-element marker
//   drained           combinational, high on the handshake of the final element
module fmap_serializer
    import cnn_pkg::*;
#(
    parameter int OUT_N = 36,
    parameter int OUT_W = 32
)
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [OUT_N*OUT_W-1:0] fmap,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [OUT_W-1:0]       m_data,
    output logic                   m_last,
    output logic                   drained
);

    localparam int CW = cnt_w(OUT_N);
    localparam logic [CW-1:0] LAST_IDX = CW'(OUT_N - 1);

    logic [OUT_N*OUT_W-1:0] snap_q, snap_d;
    logic [OUT_W-1:0]       snap_elem [OUT_N];
    logic [CW-1:0]          out_cnt_q, out_cnt_d;
    logic [CW-1:0]          nxt_cnt;
    logic                   m_valid_q, m_valid_d;
    logic [OUT_W-1:0]       m_data_q, m_data_d;
    logic                   m_last_q, m_last_d;
    logic                   handshake;

    generate
        for (genvar gi = 0; gi < OUT_N; gi++) begin : g_elem
            assign snap_elem[gi] = snap_q[gi*OUT_W +: OUT_W];
        end
    endgenerate

    assign handshake = m_valid_q && m_ready;
    assign drained   = handshake && m_last_q;
    assign nxt_cnt   = out_cnt_q + 1'b1;

    // m_data is preloaded with the next element on each handshake so the
    // output stays a plain register.
    always_comb begin
        snap_d    = snap_q;
        out_cnt_d = out_cnt_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;
        if (load) begin
            snap_d    = fmap;
            out_cnt_d = '0;
            m_valid_d = 1'b1;
            m_data_d  = fmap[OUT_W-1:0];
            m_last_d  = (LAST_IDX == '0);
        end else if (handshake) begin
            if (m_last_q) begin
                out_cnt_d = '0;
                m_valid_d = 1'b0;
                m_last_d  = 1'b0;
            end else begin
                out_cnt_d = nxt_cnt;
                m_data_d  = snap_elem[nxt_cnt];
                m_last_d  = (nxt_cnt == LAST_IDX);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_q    <= '0;
            out_cnt_q <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
        end else begin
            snap_q    <= snap_d;
            out_cnt_q <= out_cnt_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_last  = m_last_q;

endmodule

// File: rtl/cnn_dispatcher.sv
// cnn_dispatcher: host-side initiator for the convolution engine.
// Collects a raster-order pixel stream into the flat engine image bus, pulses
// eng_start, waits for a rising edge on eng_done, snapshots the feature map,
// re-arms the engine with eng_clr and streams the result out.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   s_valid/s_ready/s_data/s_last   pixel input stream
//   eng_img, eng_start, eng_done, eng_clr, eng_fmap   engine side
//   m_valid/m_ready/m_data/m_last   result output stream
//   busy                     high outside FILL
//   err_frame                pulse when s_last disagrees with the pixel count
//   err_timeout              watchdog pulse
// Optional feature: define CNN_DISP_WDT_EN to enable the WAIT-state watchdog
// (WDT_CYCLES); without it WAIT waits indefinitely and err_timeout stays 0.
module cnn_dispatcher
    import cnn_pkg::*;
#(
    parameter int IMG_W      = 8,
    parameter int IMG_H      = 8,
    parameter int PIX_W      = 32,
    parameter int OUT_W      = 32,
    parameter int WDT_CYCLES = 1024
)
(
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    s_valid,
    output logic                                    s_ready,
    input  logic [PIX_W-1:0]                        s_data,
    input  logic                                    s_last,
    output logic [img_n(IMG_W, IMG_H)*PIX_W-1:0]    eng_img,
    output logic                                    eng_start,
    input  logic                                    eng_done,
    output logic                                    eng_clr,
    input  logic [out_n(IMG_W, IMG_H)*OUT_W-1:0]    eng_fmap,
    output logic                                    m_valid,
    input  logic                                    m_ready,
    output logic [OUT_W-1:0]                        m_data,
    output logic                                    m_last,
    output logic                                    busy,
    output logic                                    err_frame,
    output logic                                    err_timeout
);

    localparam int IMG_N = img_n(IMG_W, IMG_H);
    localparam int OUT_N = out_n(IMG_W, IMG_H);
    localparam int PCW   = cnt_w(IMG_N);
    localparam logic [PCW-1:0] PIX_LAST = PCW'(IMG_N - 1);

    disp_state_e              state_q, state_d;
    logic [PCW-1:0]           pix_cnt_q, pix_cnt_d;
    logic [IMG_N*PIX_W-1:0]   img_q, img_d;
    logic                     s_ready_q, s_ready_d;
    logic                     eng_start_q, eng_start_d;
    logic                     eng_clr_q, eng_clr_d;
    logic                     err_frame_q, err_frame_d;
    logic                     err_timeout_q, err_timeout_d;
    logic                     done_prev_q;
    logic                     s_accept;
    logic                     done_edge;
    logic                     load;
    logic                     drained;
    logic                     wdt_expired;

    // s_ready_q is only ever high in FILL, so it alone qualifies a pixel beat.
    assign s_accept  = s_valid && s_ready_q;
    // done_prev_q follows eng_done in every state, so a level that is already
    // high when WAIT is entered never looks like an edge.
    assign done_edge = eng_done && !done_prev_q;

`ifdef CNN_DISP_WDT_EN
    localparam int WCW = cnt_w(WDT_CYCLES);
    localparam logic [WCW-1:0] WDT_LAST = WCW'(WDT_CYCLES - 1);

    logic [WCW-1:0] wdt_cnt_q, wdt_cnt_d;

    // Counts cycles spent in WAIT; any other state holds it at zero so it
    // is clear on every WAIT entry.
    assign wdt_cnt_d   = (state_q == ST_WAIT) ? wdt_cnt_q + 1'b1 : '0;
    assign wdt_expired = (wdt_cnt_q == WDT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdt_cnt_q <= '0;
        end else begin
            wdt_cnt_q <= wdt_cnt_d;
        end
    end
`else
    assign wdt_expired = 1'b0;
    generate
        if (WDT_CYCLES < 1) begin : g_wdt_unused
        end
    endgenerate
`endif

    always_comb begin
        state_d       = state_q;
        pix_cnt_d     = pix_cnt_q;
        img_d         = img_q;
        eng_clr_d     = 1'b0;
        err_frame_d   = 1'b0;
        err_timeout_d = 1'b0;
        load          = 1'b0;
        case (state_q)
            ST_FILL: begin
                if (s_accept) begin
                    for (int i = 0; i < IMG_N; i++) begin
                        if (pix_cnt_q == PCW'(i)) begin
                            img_d[i*PIX_W +: PIX_W] = s_data;
                        end
                    end
                    // s_last is only checked; the count alone ends the frame.
                    err_frame_d = (s_last != (pix_cnt_q == PIX_LAST));
                    if (pix_cnt_q == PIX_LAST) begin
                        pix_cnt_d = '0;
                        state_d   = ST_START;
                    end else begin
                        pix_cnt_d = pix_cnt_q + 1'b1;
                    end
                end
            end
            ST_START: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (done_edge) begin
                    load      = 1'b1;
                    eng_clr_d = 1'b1;
                    state_d   = ST_DRAIN;
                end else if (wdt_expired) begin
                    err_timeout_d = 1'b1;
                    eng_clr_d     = 1'b1;
                    state_d       = ST_FILL;
                end
            end
            ST_DRAIN: begin
                if (drained) begin
                    state_d = ST_FILL;
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
        // Registered versions of the state decode: s_ready and eng_start
        // line up exactly with the FILL and START states.
        s_ready_d   = (state_d == ST_FILL);
        eng_start_d = (state_d == ST_START);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_FILL;
            pix_cnt_q     <= '0;
            img_q         <= '0;
            s_ready_q     <= 1'b0;
            eng_start_q   <= 1'b0;
            eng_clr_q     <= 1'b0;
            err_frame_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            done_prev_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            pix_cnt_q     <= pix_cnt_d;
            img_q         <= img_d;
            s_ready_q     <= s_ready_d;
            eng_start_q   <= eng_start_d;
            eng_clr_q     <= eng_clr_d;
            err_frame_q   <= err_frame_d;
            err_timeout_q <= err_timeout_d;
            done_prev_q   <= eng_done;
        end
    end

    fmap_serializer #(
        .OUT_N (OUT_N),
        .OUT_W (OUT_W)
    ) u_fmap_serializer (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .fmap    (eng_fmap),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_last  (m_last),
        .drained (drained)
    );

    assign s_ready     = s_ready_q;
    assign eng_img     = img_q;
    assign eng_start   = eng_start_q;
    assign eng_clr     = eng_clr_q;
    assign busy        = (state_q != ST_FILL);
    assign err_frame   = err_frame_q;
    assign err_timeout = err_timeout_q;

endmodule
